// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared FSM states, opcodes and decode helpers for the multicycle datapath
package multicycle_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;
    typedef enum logic {ALU_ADD, ALU_SUB} alu_op_t;
    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] OP = 7'h33;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] LOAD = 7'h03;
    localparam logic [6:0] STORE = 7'h23;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_LW = 3'b010;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [6:0] F7_ADD = 7'h00;
    localparam logic [6:0] F7_SUB = 7'h20;
    function automatic logic is_legal(input logic [31:0] ir);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ir[14:12];
        f7 = ir[31:25];
        return ir[6:0] == OP_IMM ? f3 == F3_ADD :
               ir[6:0] == OP     ? f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB) :
               ir[6:0] == BRANCH ? f3 == F3_BEQ || f3 == F3_BNE :
               ir[6:0] == LOAD   ? f3 == F3_LW :
               ir[6:0] == STORE  ? f3 == F3_SW : 1'b0;
    endfunction
endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 2-read/1-write register array with x0 hardwired to zero and an x10 tap
module mc_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic [DATA_WIDTH-1:0] a0
);
    logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];
    // x0 is never written, so it reads back as its reset value of zero
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < 2**ADDR_WIDTH; i++) regs[i] <= '0;
        else if (we && rd_addr != '0)
            regs[rd_addr] <= rd_data;
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];
    assign a0 = regs[10];
endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: reduced RV32 core executing one instruction at a time over
// FETCH/DECODE/EXECUTE/MEM/WB with req/ready instruction and data memories
module multicycle_datapath
    import multicycle_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDRESS_WIDTH = 5,
    parameter int MEM_ADDRESS_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [MEM_ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                         imem_ready,
    input  logic [31:0]                  imem_rdata,
    output logic                         dmem_req,
    output logic                         dmem_we,
    output logic [MEM_ADDRESS_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]        dmem_wdata,
    input  logic                         dmem_ready,
    input  logic [DATA_WIDTH-1:0]        dmem_rdata,
    output logic [DATA_WIDTH-1:0]        pc,
    output logic [DATA_WIDTH-1:0]        a0,
    output logic                         halted
);
    state_t state, state_n;
    alu_op_t alu_op;
    logic active;
    logic [31:0] ir;
    logic [6:0] opcode;
    logic [DATA_WIDTH-1:0] a_q, b_q, alu_q, mdr_q, imm, alu_res, rs1_v, rs2_v, wb_data, pc_plus4;
    logic take;
    assign opcode = ir[6:0];
    assign imm = opcode == STORE  ? {{(DATA_WIDTH-12){ir[31]}}, ir[31:25], ir[11:7]} :
                 opcode == BRANCH ? {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
                                    {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
    assign alu_op = opcode == OP && ir[31:25] == F7_SUB ? ALU_SUB : ALU_ADD;
    assign alu_res = alu_op == ALU_SUB ? a_q - b_q : a_q + (opcode == OP ? b_q : imm);
    assign take = (a_q == b_q) ^ (ir[14:12] == F3_BNE);
    assign pc_plus4 = pc + DATA_WIDTH'(4);
    assign wb_data = opcode == LOAD ? mdr_q : alu_q;
    // active holds off the first fetch request until one edge after reset release
    assign imem_req = active && state == FETCH;
    assign imem_addr = pc[MEM_ADDRESS_WIDTH-1:0];
    assign dmem_req = state == MEM;
    assign dmem_we = dmem_req && opcode == STORE;
    assign dmem_addr = alu_q[MEM_ADDRESS_WIDTH-1:0];
    assign dmem_wdata = b_q;
    assign halted = state == HALT;
    mc_regfile #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(REG_ADDRESS_WIDTH)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (REG_ADDRESS_WIDTH'(ir[19:15])),
        .rs2_addr (REG_ADDRESS_WIDTH'(ir[24:20])),
        .rd_addr  (REG_ADDRESS_WIDTH'(ir[11:7])),
        .we       (state == WB),
        .rd_data  (wb_data),
        .rs1_data (rs1_v),
        .rs2_data (rs2_v),
        .a0       (a0)
    );
    always_comb begin
        state_n = state;
        case (state)
            FETCH:   state_n = imem_req && imem_ready ? DECODE : FETCH;
            DECODE:  state_n = is_legal(ir) ? EXECUTE : HALT;
            EXECUTE: state_n = opcode == BRANCH ? FETCH : (opcode == LOAD || opcode == STORE) ? MEM : WB;
            MEM:     state_n = !dmem_ready ? MEM : opcode == LOAD ? WB : FETCH;
            WB:      state_n = FETCH;
            default: state_n = HALT;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= FETCH;
            active <= 1'b0;
            pc <= RESET_PC;
            ir <= '0;
            a_q <= '0;
            b_q <= '0;
            alu_q <= '0;
            mdr_q <= '0;
        end else begin
            state <= state_n;
            active <= 1'b1;
            if (imem_req && imem_ready) ir <= imem_rdata;
            if (state == DECODE) begin
                a_q <= rs1_v;
                b_q <= rs2_v;
            end
            if (state == EXECUTE) alu_q <= alu_res;
            if (state == EXECUTE && opcode == BRANCH) pc <= take ? pc + imm : pc_plus4;
            if (state == MEM && dmem_ready && opcode == LOAD) mdr_q <= dmem_rdata;
            if (state == WB || (state == MEM && dmem_ready && opcode == STORE)) pc <= pc_plus4;
        end
endmodule
